// File: rtl/stage_pkg.sv
// Shared definitions for the five-stage instruction sequencer: stage encodings,
// wait-counter width and the packed bundle of datapath enables.
package stage_pkg;

    localparam int STAGE_W = 3;
    localparam int WAIT_W  = 4;

    typedef enum logic [STAGE_W-1:0] {
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5
    } stage_e;

    typedef struct packed {
        logic ir;
        logic pc;
        logic rom1_rd;
        logic ra;
        logic rb;
        logic rz;
        logic rm;
        logic ry;
        logic ram1_wr;
        logic rf_write;
    } stage_en_t;

endpackage

// File: rtl/stage_wait_counter.sv
// Counts MEMORY-stage wait cycles up to a limit and saturates there;
// done is high whenever the count has reached the limit.
module stage_wait_counter
    import stage_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset_L,
    input  logic              clear,
    input  logic              enable,
    input  logic [WAIT_W-1:0] limit,
    output logic              done
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != limit)) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == limit);

endmodule

// File: rtl/stage_sequencer.sv
// Five-stage (FETCH..WRITEBACK) instruction sequencer decoding per-stage
// datapath enables, with stall/flush control, NOP handling and a retire counter.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int NOP_SKIP = 1,
    parameter int CNT_W    = 8
) (
    input  logic               Clock,
    input  logic               Reset_L,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               NOP_FLAG,
    input  logic               WillWriteTo_Memory_H_RF_L,
    input  logic               Mem_Ready,
    output logic [STAGE_W-1:0] Stage,
    output logic               IR_Enable,
    output logic               PC_Enable,
    output logic               ROM1_Read,
    output logic               RA_Enable,
    output logic               RB_Enable,
    output logic               RZ_Enable,
    output logic               RM_Enable,
    output logic               RY_Enable,
    output logic               RAM1_Write_L,
    output logic               RF_WRITE,
    output logic               Instr_Done,
    output logic [CNT_W-1:0]   Instr_Count
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = MEM_WAIT[WAIT_W-1:0];
    localparam logic              SKIP_NOPS  = (NOP_SKIP != 0);

    stage_e     state_q, state_d;
    logic       nop_q, nop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    stage_en_t  en;
    stage_en_t  en_out;
    logic       done_raw;
    logic       wait_clear;
    logic       wait_en;
    logic       wait_done;

    stage_wait_counter u_wait (
        .Clock   (Clock),
        .Reset_L (Reset_L),
        .clear   (wait_clear),
        .enable  (wait_en),
        .limit   (WAIT_LIMIT),
        .done    (wait_done)
    );

    // Mem_Ready handshake: MEMORY completes in the single cycle where the wait
    // count has reached MEM_WAIT and Mem_Ready is high; it is ignored elsewhere.
    always_comb begin
        state_d    = state_q;
        nop_d      = nop_q;
        wait_clear = 1'b0;
        wait_en    = 1'b0;
        en         = '0;
        done_raw   = 1'b0;

        if (Flush) begin
            state_d    = ST_FETCH;
            nop_d      = 1'b0;
            wait_clear = 1'b1;
        end else if (!Stall) begin
            case (state_q)
                ST_FETCH: begin
                    en.ir      = 1'b1;
                    en.pc      = 1'b1;
                    en.rom1_rd = 1'b1;
                    nop_d      = 1'b0;
                    state_d    = ST_DECODE;
                end
                ST_DECODE: begin
                    if (NOP_FLAG && SKIP_NOPS) begin
                        done_raw = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        nop_d   = NOP_FLAG;
                        en.ra   = !NOP_FLAG;
                        en.rb   = !NOP_FLAG;
                        state_d = ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    en.rz      = !nop_q;
                    en.rm      = !nop_q;
                    wait_clear = 1'b1;
                    state_d    = ST_MEMORY;
                end
                ST_MEMORY: begin
                    // A walking NOP keeps normal MEMORY timing, just without enables.
                    wait_en = 1'b1;
                    if (wait_done && Mem_Ready) begin
                        en.ry      = !nop_q;
                        en.ram1_wr = !nop_q && WillWriteTo_Memory_H_RF_L;
                        state_d    = ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    en.rf_write = !nop_q && !WillWriteTo_Memory_H_RF_L;
                    done_raw    = 1'b1;
                    nop_d       = 1'b0;
                    state_d     = ST_FETCH;
                end
                default: begin
                    nop_d      = 1'b0;
                    wait_clear = 1'b1;
                    state_d    = ST_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (Instr_Done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_L) begin
            state_q <= ST_FETCH;
            nop_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            nop_q   <= nop_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall and Flush already suppress enables above; reset is gated here.
    assign en_out     = Reset_L ? en : '0;
    assign Instr_Done = Reset_L && done_raw;

    assign Stage        = state_q;
    assign IR_Enable    = en_out.ir;
    assign PC_Enable    = en_out.pc;
    assign ROM1_Read    = en_out.rom1_rd;
    assign RA_Enable    = en_out.ra;
    assign RB_Enable    = en_out.rb;
    assign RZ_Enable    = en_out.rz;
    assign RM_Enable    = en_out.rm;
    assign RY_Enable    = en_out.ry;
    assign RAM1_Write_L = en_out.ram1_wr;
    assign RF_WRITE     = en_out.rf_write;
    assign Instr_Count  = cnt_q;

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter MEM_WAIT, default 0: extra wait cycles spent in MEMORY before it may complete; legal range 0..15.
REQ-002 Parameter NOP_SKIP, default 1: 1 = a NOP returns to FETCH straight after DECODE; 0 = a NOP walks all five stages with datapath enables suppressed.
REQ-003 Parameter CNT_W, default 8: width of the retired-instruction counter.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset_L  input  1  synchronous, active-low reset.
REQ-006 Stall  input  1  freezes the sequencer for the current cycle.
REQ-007 Flush  input  1  abandons the current instruction and returns to FETCH.
REQ-008 NOP_FLAG  input  1  current instruction is a NOP; sampled in DECODE only.
REQ-009 WillWriteTo_Memory_H_RF_L  input  1  1 = result goes to RAM, 0 = result goes to the register file.
REQ-010 Mem_Ready  input  1  memory handshake; MEMORY may complete only while it is high.
REQ-011 Stage  output  3  current stage: 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEMORY, 5 WRITEBACK.
REQ-012 IR_Enable, PC_Enable, ROM1_Read  output  1 each  fetch enables.
REQ-013 RA_Enable, RB_Enable  output  1 each  decode enables.
REQ-014 RZ_Enable, RM_Enable  output  1 each  execute enables.
REQ-015 RY_Enable, RAM1_Write_L  output  1 each  memory enables.
REQ-016 RF_WRITE  output  1  writeback enable.
REQ-017 Instr_Done  output  1  one-cycle pulse when an instruction retires.
REQ-018 Instr_Count  output  CNT_W  count of retired instructions.

Function
REQ-019 The FSM SHALL hold one of FETCH, DECODE, EXECUTE, MEMORY or WRITEBACK, held in a registered state; Stage SHALL equal the state encoding.
REQ-020 Enables SHALL be decoded from the registered state and SHALL be 0 in any cycle with Stall=1, Flush=1 or Reset_L=0.
REQ-021 FETCH: IR_Enable=PC_Enable=ROM1_Read=1; next state DECODE.
REQ-022 DECODE, NOP_FLAG=0: RA_Enable=RB_Enable=1; next state EXECUTE.
REQ-023 DECODE, NOP_FLAG=1, NOP_SKIP=1: no enables; Instr_Done=1; next state FETCH.
REQ-024 DECODE, NOP_FLAG=1, NOP_SKIP=0: a NOP marker is latched; in EXECUTE, MEMORY and WRITEBACK all datapath enables SHALL be 0 while state still advances; the marker clears on return to FETCH.
REQ-025 EXECUTE: RZ_Enable=RM_Enable=1; next state MEMORY; the wait counter is cleared.
REQ-026 MEMORY: the wait counter increments each unstalled cycle until it equals MEM_WAIT, then saturates.
REQ-027 MEMORY completes only in the cycle where the count equals MEM_WAIT and Mem_Ready=1.
REQ-028 On the MEMORY completion cycle: RY_Enable=1, RAM1_Write_L=WillWriteTo_Memory_H_RF_L; next state WRITEBACK. In all other MEMORY cycles both are 0.
REQ-029 WRITEBACK: RF_WRITE = NOT WillWriteTo_Memory_H_RF_L; Instr_Done=1; next state FETCH.
REQ-030 Latency per instruction SHALL be 5+MEM_WAIT cycles, plus one per Mem_Ready-low cycle and one per Stall cycle; a NOP with NOP_SKIP=1 takes 2 cycles.
REQ-031 Stall=1: state, wait counter and NOP marker SHALL hold, and Instr_Done=0.
REQ-032 Flush=1: next state FETCH, NOP marker and wait counter cleared, Instr_Done=0; Flush overrides Stall; Flush in FETCH re-enters FETCH.
REQ-033 Instr_Count SHALL increment on every Instr_Done and wrap from 2^CNT_W-1 to 0.
REQ-034 Mem_Ready SHALL be ignored outside MEMORY.

Reset
REQ-035 Reset_L=0 at a rising edge SHALL set state FETCH, wait counter 0, NOP marker 0 and Instr_Count 0, and SHALL hold all enables and Instr_Done at 0 while Reset_L stays low.
REQ-036 Reset asserted mid-instruction SHALL abandon that instruction without any RF_WRITE or RAM1_Write_L pulse.
REQ-037 The first cycle after Reset_L rises SHALL be FETCH with the fetch enables asserted.

Structure
REQ-038 The stage encodings (1..5) and the Stage width (3) SHALL live in the shared package stage_pkg, for reuse by the decoder and the bench.
REQ-039 The MEMORY wait counter SHALL be a sub-module stage_wait_counter (inputs clear, enable, limit; output done).

Verification
REQ-040 MEM_WAIT=0, Mem_Ready=1, ALU op with WillWrite=0 -> Stage runs 1,2,3,4,5; RF_WRITE pulses in cycle 5; Instr_Count 0->1.
REQ-041 MEM_WAIT=2, store with WillWrite=1, Mem_Ready low for 1 extra cycle -> MEMORY lasts 4 cycles; RAM1_Write_L and RY_Enable high only in the last of them; RF_WRITE stays 0.
REQ-042 NOP_FLAG=1 with NOP_SKIP=1 -> Stage 1,2,1; Instr_Done in cycle 2. Same with NOP_SKIP=0 -> Stage 1..5 with only fetch enables ever asserted.
REQ-043 Stall held 3 cycles in EXECUTE, then Flush asserted together with Stall in MEMORY -> Stage frozen at 3 with enables 0 for 3 cycles; next stage 1; no RY, RF or RAM pulse.
REQ-044 Reset_L low for one cycle in MEMORY, and CNT_W=2 with 5 retirements -> outputs 0 during reset, then FETCH; Instr_Count reads 1 after wrapping.
